cache_fill_fsm: RTL and testbench
=================================

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, byte-address width of the miss and memory addresses.
REQ-002 Parameter BLOCK_WORDS, default 8, number of 16-bit words per cache block (16 bytes).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 miss_detected  input  1  cache tag compare reports a miss this cycle.
REQ-006 miss_address  input  ADDR_WIDTH  byte address of the missing access.
REQ-007 memory_data_valid  input  1  memory_data carries a returned word this cycle.
REQ-008 memory_data  input  16  word returned by memory.
REQ-009 fsm_busy  output  1  fill in progress; pipeline stalls while high.
REQ-010 memory_enable  output  1  read request to memory, with the write strobe always 0.
REQ-011 memory_address  output  ADDR_WIDTH  word-aligned read address; bit 0 is always 0.
REQ-012 write_data_array  output  1  write cache_data_out into the data array at cache_word_index.
REQ-013 cache_word_index  output  3  word slot within the block.
REQ-014 cache_data_out  output  16  word to write; equals memory_data combinationally.
REQ-015 write_tag_array  output  1  one-cycle pulse that writes tag/valid for the filled block.

Function
REQ-016 States SHALL be IDLE and FILL only.
REQ-017 IDLE with miss_detected=1 SHALL latch base = miss_address with bits [3:0] cleared and latch the start word = miss_address[3:1], then go to FILL next cycle.
REQ-018 In FILL, while issue_cnt < BLOCK_WORDS, memory_enable SHALL be 1 and memory_address SHALL be base + 2*word(issue_cnt); issue_cnt increments each cycle.
REQ-019 The issue counter and the receive counter SHALL be independent, so that memory with latency of 0..N cycles is supported; memory_data_valid is counted only in FILL and only while recv_cnt < BLOCK_WORDS.
REQ-020 On each counted memory_data_valid, write_data_array=1 and cache_word_index=word(recv_cnt) SHALL be driven in the same cycle, and recv_cnt SHALL increment.
REQ-021 The cycle that counts the 8th word SHALL assert write_tag_array for exactly that cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-022 fsm_busy SHALL be 1 in every FILL cycle and 0 in IDLE.
REQ-023 With zero-latency memory (valid = enable), miss at cycle 0 SHALL give FILL for cycles 1-8, the tag write in cycle 8, and fsm_busy=0 in cycle 9.
REQ-024 miss_detected while in FILL SHALL be ignored, and a new miss SHALL be accepted only in IDLE.
REQ-025 memory_data_valid in IDLE SHALL be ignored, with no array writes.
REQ-026 Address arithmetic SHALL be modulo 2^ADDR_WIDTH: base 0xFFF0 issues 0xFFF0..0xFFFE and never carries out.
REQ-027 All outputs not listed as active in a state SHALL be 0.

Reset
REQ-028 rst=1 at an edge SHALL force IDLE, clear issue_cnt, recv_cnt, base and the start word, and drive all outputs to 0 from the next cycle.
REQ-029 Reset in the middle of a fill SHALL abandon the fill with no tag write; returns still in flight after reset are ignored under REQ-025.

Configuration
REQ-030 Macro CACHE_FILL_CWF_EN: when defined, word(n) = (start word + n) mod 8, so the critical word is fetched first and the order wraps; when undefined, word(n) = n and the start word is unused.

Structure
REQ-031 Package cache_fill_pkg SHALL hold the state enum, BLOCK_WORDS, the block offset width (4) and the word index width (3).
REQ-032 One sub-module, fill_counter (3-bit counter with clear, enable and a terminal flag), SHALL be instantiated twice: once for issue and once for receive.

Verification
REQ-033 Zero-latency fill: miss at 0x1234 with CWF off -> addresses 0x1230,0x1232..0x123E in cycles 1-8, indices 0..7, write_tag_array in cycle 8 only.
REQ-034 CWF on, miss at 0x123A -> addresses 0x123A,0x123C,0x123E,0x1230..0x1238 and indices 5,6,7,0..4.
REQ-035 4-cycle memory latency -> all 8 addresses issued in cycles 1-8, writes in cycles 5-12, tag pulse in cycle 12, fsm_busy low in cycle 13.
REQ-036 Wrap: miss at 0xFFFE with CWF off -> last address 0xFFFE and no access at 0x0000.
REQ-037 Second miss_detected at cycle 3 of a fill -> ignored; exactly one tag pulse is produced.
REQ-038 rst asserted in cycle 4 of a fill -> all outputs 0 from cycle 5, no tag write; a new miss in cycle 6 starts a clean fill.

Source files
------------

// File: rtl/cache_fill_pkg.sv
// Shared types and sizes for the cache block fill engine.
// A block is 8 words of 16 bits, so 4 byte-offset bits and a 3-bit word index.
package cache_fill_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

  localparam int BLOCK_WORDS = 8;
  localparam int OFFSET_W    = 4;
  localparam int IDX_W       = 3;

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// Word counter for one side of a fill: counts enabled cycles up to LAST and then holds done.
// Single-cycle update, no backpressure; clear has priority over enable.
module fill_counter #(
  parameter int           W    = 3,
  parameter logic [W-1:0] LAST = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         last_o,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (clr_i) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (en_i && !done_q) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) done_d = 1'b1;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = !done_q && (cnt_q == LAST);
  assign done_o = done_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss block fill: issues 8 word reads, writes returns into the data array, pulses the tag write.
// Fill takes 8 cycles plus memory latency; memory is never stalled. CACHE_FILL_CWF_EN selects critical-word-first order.
module cache_fill_fsm #(
  parameter int ADDR_WIDTH  = 16,
  parameter int BLOCK_WORDS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_detected,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  input  logic                  memory_data_valid,
  input  logic [15:0]           memory_data,
  output logic                  fsm_busy,
  output logic                  memory_enable,
  output logic [ADDR_WIDTH-1:0] memory_address,
  output logic                  write_data_array,
  output logic [2:0]            cache_word_index,
  output logic [15:0]           cache_data_out,
  output logic                  write_tag_array
);

  import cache_fill_pkg::*;

  fill_state_e                    state_q, state_d;
  logic [ADDR_WIDTH-OFFSET_W-1:0] base_q, base_d;
  logic [IDX_W-1:0]               start_q, start_d;

  logic [IDX_W-1:0] issue_cnt, recv_cnt;
  logic             issue_done, recv_done, recv_last, issue_last_unused;
  logic [IDX_W-1:0] issue_word, recv_word;
  logic             cnt_clr, issue_en, recv_en;
  logic             unused_bits;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      start_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      start_q <= start_d;
    end
  end

  // Counters restart whenever the FSM sits in IDLE, so a miss taken there starts from word 0.
  assign cnt_clr  = (state_q == IDLE);
  assign issue_en = (state_q == FILL) && !issue_done;
  assign recv_en  = (state_q == FILL) && memory_data_valid && !recv_done;

  fill_counter #(.W(IDX_W), .LAST(IDX_W'(BLOCK_WORDS - 1))) u_issue_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .en_i   (issue_en),
    .cnt_o  (issue_cnt),
    .last_o (issue_last_unused),
    .done_o (issue_done)
  );

  fill_counter #(.W(IDX_W), .LAST(IDX_W'(BLOCK_WORDS - 1))) u_recv_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .en_i   (recv_en),
    .cnt_o  (recv_cnt),
    .last_o (recv_last),
    .done_o (recv_done)
  );

`ifdef CACHE_FILL_CWF_EN
  // 3-bit sums wrap naturally, giving the modulo-8 critical-word-first order.
  assign issue_word = start_q + issue_cnt;
  assign recv_word  = start_q + recv_cnt;
`else
  assign issue_word = issue_cnt;
  assign recv_word  = recv_cnt;
`endif

  assign unused_bits    = ^{start_q, miss_address[0], issue_last_unused};
  assign cache_data_out = memory_data;

  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    start_d          = start_q;
    fsm_busy         = 1'b0;
    memory_enable    = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    cache_word_index = '0;
    write_tag_array  = 1'b0;

    case (state_q)
      IDLE: begin
        if (miss_detected) begin
          base_d  = miss_address[ADDR_WIDTH-1:OFFSET_W];
          start_d = miss_address[OFFSET_W-1:1];
          state_d = FILL;
        end
      end
      FILL: begin
        fsm_busy = 1'b1;
        if (!issue_done) begin
          memory_enable  = 1'b1;
          // Block offset is concatenated, never added, so the address cannot carry out of the block.
          memory_address = {base_q, issue_word, 1'b0};
        end
        if (recv_en) begin
          write_data_array = 1'b1;
          cache_word_index = recv_word;
          if (recv_last) begin
            write_tag_array = 1'b1;
            state_d         = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scenario bench for cache_fill_fsm with a variable-latency memory model and an event scoreboard.
module tb_cache_fill_fsm;

`ifdef CACHE_FILL_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic        memory_data_valid = 1'b0;
  logic [15:0] memory_data = '0;
  logic        fsm_busy, memory_enable, write_data_array, write_tag_array;
  logic [15:0] memory_address, cache_data_out;
  logic [2:0]  cache_word_index;

  cache_fill_fsm #(.ADDR_WIDTH(16), .BLOCK_WORDS(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .fsm_busy          (fsm_busy),
    .memory_enable     (memory_enable),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .cache_word_index  (cache_word_index),
    .cache_data_out    (cache_data_out),
    .write_tag_array   (write_tag_array)
  );

  always #5 clk = ~clk;

  // kind: 0 = read issued, 1 = data array write, 2 = tag write
  typedef struct packed {
    logic [7:0]  cyc;
    logic [1:0]  kind;
    logic [15:0] val;
    logic [15:0] dat;
  } ev_t;

  typedef struct {
    int          due;
    logic [15:0] a;
  } req_t;

  ev_t  exp_q[$];
  ev_t  obs_q[$];
  req_t pend[$];
  int   cyc;
  int   lat;
  logic busy_at[0:63];
  logic en_at[0:63];
  int   tests  = 0;
  int   failed = 0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'hA5C3;
  endfunction

  // One clock cycle: drive inputs, play the memory model, record DUT events.
  task automatic tick(input bit miss, input logic [15:0] maddr, input bit r);
    @(negedge clk);
    rst           = r;
    miss_detected = miss;
    miss_address  = maddr;
    #1;
    if (memory_enable === 1'b1) begin
      obs_q.push_back(ev_t'{cyc[7:0], 2'd0, memory_address, 16'h0});
      pend.push_back(req_t'{cyc + lat, memory_address});
    end
    if (pend.size() > 0 && pend[0].due == cyc) begin
      memory_data_valid = 1'b1;
      memory_data       = mem_word(pend[0].a);
      void'(pend.pop_front());
    end else begin
      memory_data_valid = 1'b0;
      memory_data       = 16'($urandom);
    end
    #1;
    if (write_data_array === 1'b1)
      obs_q.push_back(ev_t'{cyc[7:0], 2'd1, {13'h0, cache_word_index}, cache_data_out});
    if (write_tag_array === 1'b1)
      obs_q.push_back(ev_t'{cyc[7:0], 2'd2, 16'h0, 16'h0});
    busy_at[cyc] = fsm_busy;
    en_at[cyc]   = memory_enable;
    @(posedge clk);
    cyc++;
  endtask

  // Expected events of a fill whose miss is seen in cycle m; events after cycle cut are dropped.
  task automatic expect_fill(input int m, input logic [15:0] a, input int l, input int cut);
    logic [15:0] base, wa;
    logic [2:0]  s, w;
    base = a & 16'hFFF0;
    s    = a[3:1];
    for (int n = 0; n < 8; n++) begin
      w  = CWF ? 3'(s + 3'(n)) : 3'(n);
      wa = base | {12'h0, w, 1'b0};
      if (m + 1 + n <= cut) exp_q.push_back(ev_t'{8'(m + 1 + n), 2'd0, wa, 16'h0});
      if (m + 1 + n + l <= cut) exp_q.push_back(ev_t'{8'(m + 1 + n + l), 2'd1, {13'h0, w}, mem_word(wa)});
    end
    if (m + 8 + l <= cut) exp_q.push_back(ev_t'{8'(m + 8 + l), 2'd2, 16'h0, 16'h0});
    exp_q.sort();
  endtask

  task automatic start_scenario(input int l);
    cyc = 0;
    lat = l;
    exp_q.delete();
    obs_q.delete();
    pend.delete();
  endtask

  task automatic test_reset();
    start_scenario(0);
    tick(0, 16'h0, 1);
    tick(0, 16'h0, 1);
    tick(0, 16'h0, 0);
    tick(0, 16'h0, 0);
    for (int c = 2; c < 4; c++) begin
      tests++;
      if (busy_at[c] !== 1'b0 || en_at[c] !== 1'b0) begin
        failed++;
        $display("FAIL reset_outputs cyc%0d: busy=%b en=%b, expected 0/0", c, busy_at[c], en_at[c]);
      end
    end
    tests++;
    if (obs_q.size() != 0) begin
      failed++;
      $display("FAIL reset_events: %0d events after reset, expected 0", obs_q.size());
    end
  endtask

  task automatic test_zero_latency();
    ev_t e, o;
    start_scenario(0);
    expect_fill(0, 16'h1234, 0, 255);
    for (int c = 0; c < 12; c++) tick(c == 0, 16'h1234, 0);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin
        failed++;
        $display("FAIL zero_lat_event: got cyc=%0d kind=%0d val=%h dat=%h, expected cyc=%0d kind=%0d val=%h dat=%h",
                 o.cyc, o.kind, o.val, o.dat, e.cyc, e.kind, e.val, e.dat);
      end
    end
    tests++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      failed++;
      $display("FAIL zero_lat_count: %0d unmatched expected, %0d unexpected observed", exp_q.size(), obs_q.size());
    end
    for (int c = 0; c < 11; c++) begin
      tests++;
      if (busy_at[c] !== (c >= 1 && c <= 8)) begin
        failed++;
        $display("FAIL zero_lat_busy cyc%0d: got %b, expected %b", c, busy_at[c], (c >= 1 && c <= 8));
      end
    end
  endtask

  task automatic test_cwf();
    ev_t e, o;
    start_scenario(0);
    expect_fill(0, 16'h123A, 0, 255);
    for (int c = 0; c < 12; c++) tick(c == 0, 16'h123A, 0);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin
        failed++;
        $display("FAIL cwf_event: got cyc=%0d kind=%0d val=%h dat=%h, expected cyc=%0d kind=%0d val=%h dat=%h",
                 o.cyc, o.kind, o.val, o.dat, e.cyc, e.kind, e.val, e.dat);
      end
    end
    tests++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      failed++;
      $display("FAIL cwf_count: %0d unmatched expected, %0d unexpected observed", exp_q.size(), obs_q.size());
    end
  endtask

  task automatic test_latency4();
    ev_t e, o;
    start_scenario(4);
    expect_fill(0, 16'h0100, 4, 255);
    for (int c = 0; c < 16; c++) tick(c == 0, 16'h0100, 0);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin
        failed++;
        $display("FAIL lat4_event: got cyc=%0d kind=%0d val=%h dat=%h, expected cyc=%0d kind=%0d val=%h dat=%h",
                 o.cyc, o.kind, o.val, o.dat, e.cyc, e.kind, e.val, e.dat);
      end
    end
    tests++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      failed++;
      $display("FAIL lat4_count: %0d unmatched expected, %0d unexpected observed", exp_q.size(), obs_q.size());
    end
    tests++;
    if (busy_at[12] !== 1'b1 || busy_at[13] !== 1'b0 || en_at[9] !== 1'b0) begin
      failed++;
      $display("FAIL lat4_busy: busy12=%b busy13=%b en9=%b, expected 1/0/0", busy_at[12], busy_at[13], en_at[9]);
    end
  endtask

  task automatic test_wrap();
    ev_t e, o;
    int  zero_hits;
    start_scenario(1);
    expect_fill(0, 16'hFFFE, 1, 255);
    for (int c = 0; c < 13; c++) tick(c == 0, 16'hFFFE, 0);
    zero_hits = 0;
    foreach (obs_q[i]) if (obs_q[i].kind == 2'd0 && obs_q[i].val == 16'h0000) zero_hits++;
    tests++;
    if (zero_hits != 0) begin
      failed++;
      $display("FAIL wrap_no_zero: %0d reads at 0x0000, expected 0", zero_hits);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin
        failed++;
        $display("FAIL wrap_event: got cyc=%0d kind=%0d val=%h dat=%h, expected cyc=%0d kind=%0d val=%h dat=%h",
                 o.cyc, o.kind, o.val, o.dat, e.cyc, e.kind, e.val, e.dat);
      end
    end
    tests++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      failed++;
      $display("FAIL wrap_count: %0d unmatched expected, %0d unexpected observed", exp_q.size(), obs_q.size());
    end
  endtask

  task automatic test_second_miss();
    ev_t e, o;
    int  tags;
    start_scenario(0);
    expect_fill(0, 16'h5678, 0, 255);
    for (int c = 0; c < 12; c++) tick(c == 0 || c == 3, (c == 3) ? 16'h4444 : 16'h5678, 0);
    tags = 0;
    foreach (obs_q[i]) if (obs_q[i].kind == 2'd2) tags++;
    tests++;
    if (tags != 1) begin
      failed++;
      $display("FAIL second_miss_tags: %0d tag pulses, expected 1", tags);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin
        failed++;
        $display("FAIL second_miss_event: got cyc=%0d kind=%0d val=%h dat=%h, expected cyc=%0d kind=%0d val=%h dat=%h",
                 o.cyc, o.kind, o.val, o.dat, e.cyc, e.kind, e.val, e.dat);
      end
    end
    tests++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      failed++;
      $display("FAIL second_miss_count: %0d unmatched expected, %0d unexpected observed", exp_q.size(), obs_q.size());
    end
  endtask

  task automatic test_idle_valid();
    start_scenario(0);
    pend.push_back(req_t'{1, 16'h1110});
    pend.push_back(req_t'{2, 16'h1112});
    pend.push_back(req_t'{3, 16'h1114});
    for (int c = 0; c < 5; c++) tick(0, 16'h0, 0);
    tests++;
    if (obs_q.size() != 0 || busy_at[2] !== 1'b0) begin
      failed++;
      $display("FAIL idle_valid: %0d events busy=%b, expected 0 events busy=0", obs_q.size(), busy_at[2]);
    end
  endtask

  task automatic test_reset_mid_fill();
    ev_t e, o;
    start_scenario(2);
    expect_fill(0, 16'h2000, 2, 4);
    expect_fill(6, 16'h2468, 2, 255);
    for (int c = 0; c < 19; c++) tick(c == 0 || c == 6, (c == 0) ? 16'h2000 : 16'h2468, c == 4);
    tests++;
    if (busy_at[5] !== 1'b0 || en_at[5] !== 1'b0 || busy_at[6] !== 1'b0) begin
      failed++;
      $display("FAIL rst_mid_idle: busy5=%b en5=%b busy6=%b, expected 0/0/0", busy_at[5], en_at[5], busy_at[6]);
    end
    tests++;
    if (busy_at[16] !== 1'b1 || busy_at[17] !== 1'b0) begin
      failed++;
      $display("FAIL rst_mid_refill_busy: busy16=%b busy17=%b, expected 1/0", busy_at[16], busy_at[17]);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin
        failed++;
        $display("FAIL rst_mid_event: got cyc=%0d kind=%0d val=%h dat=%h, expected cyc=%0d kind=%0d val=%h dat=%h",
                 o.cyc, o.kind, o.val, o.dat, e.cyc, e.kind, e.val, e.dat);
      end
    end
    tests++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      failed++;
      $display("FAIL rst_mid_count: %0d unmatched expected, %0d unexpected observed", exp_q.size(), obs_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_zero_latency();
    test_cwf();
    test_latency4();
    test_wrap();
    test_second_miss();
    test_idle_valid();
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
